// File: rtl/eacs_213.sv
`default_nettype none
// ============================================================================
// Module   : eacs_213
// Purpose  : Add-compare-select unit for a (2,1,3) backward-label Viterbi
//            decoder. Eight saturating path metrics with MSB renormalisation,
//            per-step survivor decisions, best state/metric and a step count.
// Revision : 1.0  initial release
// ============================================================================
module eacs_213 #(
  parameter int PM_W    = 6,
  parameter int PM_INIT = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            bm_valid,
  input  logic [1:0]      HD1,
  input  logic [1:0]      HD2,
  input  logic [1:0]      HD3,
  input  logic [1:0]      HD4,
  input  logic [1:0]      HD5,
  input  logic [1:0]      HD6,
  input  logic [1:0]      HD7,
  input  logic [1:0]      HD8,
  input  logic [1:0]      HD9,
  input  logic [1:0]      HD10,
  input  logic [1:0]      HD11,
  input  logic [1:0]      HD12,
  input  logic [1:0]      HD13,
  input  logic [1:0]      HD14,
  input  logic [1:0]      HD15,
  input  logic [1:0]      HD16,
  output logic [7:0]      dec,
  output logic            dec_valid,
  output logic [2:0]      best_state,
  output logic [PM_W-1:0] best_metric,
  output logic [7:0]      step,
  output logic            busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state;
  logic [PM_W-1:0] pm     [8];
  logic [PM_W-1:0] pm_adj [8];
  logic [PM_W-1:0] pm_new [8];
  logic [1:0]      bm     [16];
  logic [7:0]      msb;
  logic            renorm;
  logic [7:0]      dec_new;
  logic [2:0]      best_idx;
  logic [PM_W-1:0] best_val;
  logic [7:0]      step_cnt;

  // Add a 2-bit branch metric in PM_W+1 bits and clamp at the all-ones value
  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a,
                                              input logic [1:0]      b);
    logic [PM_W:0] s;
    s = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
    return s[PM_W] ? {PM_W{1'b1}} : s[PM_W-1:0];
  endfunction

  // Branch b (= 2*predecessor + input bit) uses HD(b+1)
  assign bm[0]  = HD1;
  assign bm[1]  = HD2;
  assign bm[2]  = HD3;
  assign bm[3]  = HD4;
  assign bm[4]  = HD5;
  assign bm[5]  = HD6;
  assign bm[6]  = HD7;
  assign bm[7]  = HD8;
  assign bm[8]  = HD9;
  assign bm[9]  = HD10;
  assign bm[10] = HD11;
  assign bm[11] = HD12;
  assign bm[12] = HD13;
  assign bm[13] = HD14;
  assign bm[14] = HD15;
  assign bm[15] = HD16;

  // When every metric has its MSB set, clearing the MSB shifts all of them
  // down by the same amount, so relative metrics are unchanged.
  genvar g;
  for (g = 0; g < 8; g++) begin : g_renorm
    assign msb[g]    = pm[g][PM_W-1];
    assign pm_adj[g] = renorm ? {1'b0, pm[g][PM_W-2:0]} : pm[g];
  end
  assign renorm = &msb;

  // New state s' = {s[1:0], u}; predecessors are {0, s'[2:1]} and {1, s'[2:1]}
  for (g = 0; g < 8; g++) begin : g_acs
    localparam int PLO = g / 2;
    localparam int PHI = g / 2 + 4;
    localparam int U   = g % 2;
    logic [PM_W-1:0] c_lo;
    logic [PM_W-1:0] c_hi;
    assign c_lo       = sat_add(pm_adj[PLO], bm[2*PLO+U]);
    assign c_hi       = sat_add(pm_adj[PHI], bm[2*PHI+U]);
    // Ties keep the low predecessor
    assign dec_new[g] = (c_hi < c_lo);
    assign pm_new[g]  = dec_new[g] ? c_hi : c_lo;
  end

  // Minimum of the updated metrics, lowest index wins ties
  always_comb begin
    best_idx = 3'd0;
    best_val = pm_new[0];
    for (int i = 1; i < 8; i++) begin
      if (pm_new[i] < best_val) begin
        best_val = pm_new[i];
        best_idx = 3'(i);
      end
    end
  end

  // Control FSM, metric registers and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      for (int i = 0; i < 8; i++) pm[i] <= '0;
      dec         <= '0;
      dec_valid   <= 1'b0;
      best_state  <= '0;
      best_metric <= '0;
      step        <= '0;
      step_cnt    <= '0;
      busy        <= 1'b0;
    end else begin
      dec_valid <= 1'b0;
      if (start) begin
        pm[0] <= '0;
        for (int i = 1; i < 8; i++) pm[i] <= PM_W'(PM_INIT);
        step_cnt <= '0;
        state    <= RUN;
        busy     <= 1'b1;
      end else begin
        case (state)
          RUN: begin
            if (bm_valid) begin
              for (int i = 0; i < 8; i++) pm[i] <= pm_new[i];
              dec         <= dec_new;
              best_state  <= best_idx;
              best_metric <= best_val;
              step        <= step_cnt;
              step_cnt    <= step_cnt + 8'd1;
              dec_valid   <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eacs_213.sv
`default_nettype none
// ============================================================================
// Module   : tb_eacs_213
// Purpose  : Self-checking bench for eacs_213 against a behavioural model of
//            the add-compare-select rules using integer path metrics.
// Revision : 1.0  initial release
// ============================================================================
module tb_eacs_213;

  localparam int PM_W    = 6;
  localparam int PM_INIT = 16;
  localparam int PM_MAX  = (1 << PM_W) - 1;
  localparam int HALF    = 1 << (PM_W - 1);

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            bm_valid = 1'b0;
  logic [1:0]      hd [16];
  logic [7:0]      dec;
  logic            dec_valid;
  logic [2:0]      best_state;
  logic [PM_W-1:0] best_metric;
  logic [7:0]      step;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_pm [8];
  bit m_run;
  int m_step;
  int exp_dec, exp_best, exp_bm, exp_step;
  bit exp_dv;

  eacs_213 #(.PM_W(PM_W), .PM_INIT(PM_INIT)) dut (
    .clock(clock), .reset(reset), .start(start), .bm_valid(bm_valid),
    .HD1(hd[0]),   .HD2(hd[1]),   .HD3(hd[2]),   .HD4(hd[3]),
    .HD5(hd[4]),   .HD6(hd[5]),   .HD7(hd[6]),   .HD8(hd[7]),
    .HD9(hd[8]),   .HD10(hd[9]),  .HD11(hd[10]), .HD12(hd[11]),
    .HD13(hd[12]), .HD14(hd[13]), .HD15(hd[14]), .HD16(hd[15]),
    .dec(dec), .dec_valid(dec_valid), .best_state(best_state),
    .best_metric(best_metric), .step(step), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_pm[i] = 0;
    m_run = 0; m_step = 0;
    exp_dec = 0; exp_best = 0; exp_bm = 0; exp_step = 0; exp_dv = 0;
  endtask

  // One trellis step computed from the decoder rules with plain integers
  task automatic model_update(input bit st, input bit v);
    int np [8];
    int cand [2];
    bit all_high;
    exp_dv = 0;
    if (st) begin
      m_pm[0] = 0;
      for (int i = 1; i < 8; i++) m_pm[i] = PM_INIT;
      m_step = 0;
      m_run  = 1;
    end else if (v && m_run) begin
      all_high = 1;
      for (int i = 0; i < 8; i++) if (m_pm[i] < HALF) all_high = 0;
      if (all_high) for (int i = 0; i < 8; i++) m_pm[i] -= HALF;
      exp_dec = 0;
      for (int ns = 0; ns < 8; ns++) begin
        for (int k = 0; k < 2; k++) begin
          int p;
          p = ns / 2 + 4 * k;
          cand[k] = m_pm[p] + int'(hd[2 * p + ns % 2]);
          if (cand[k] > PM_MAX) cand[k] = PM_MAX;
        end
        if (cand[1] < cand[0]) begin
          np[ns] = cand[1];
          exp_dec |= (1 << ns);
        end else begin
          np[ns] = cand[0];
        end
      end
      exp_best = 0;
      for (int i = 1; i < 8; i++) if (np[i] < np[exp_best]) exp_best = i;
      for (int i = 0; i < 8; i++) m_pm[i] = np[i];
      exp_bm   = np[exp_best];
      exp_step = m_step;
      m_step   = (m_step + 1) % 256;
      exp_dv   = 1;
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge
  task automatic apply(input bit st, input bit v);
    @(negedge clock);
    start = st; bm_valid = v;
    @(posedge clock);
    model_update(st, v);
    #1;
  endtask

  task automatic set_hd_all(input int val);
    for (int i = 0; i < 16; i++) hd[i] = 2'(val);
  endtask

  task automatic set_hd_rand();
    for (int i = 0; i < 16; i++) hd[i] = 2'($urandom_range(0, 2));
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if ({dec, dec_valid, best_state, best_metric, step, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got dec=%h dv=%b bs=%0d bm=%0d step=%0d busy=%b required all zero",
               dec, dec_valid, best_state, best_metric, step, busy);
    end
    @(negedge clock); reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      set_hd_rand();
      apply(0, 1);
      n_checks++;
      if ({dec, dec_valid, best_state, best_metric, step, busy} !== '0) begin
        n_fail++;
        $display("FAIL idle_ignore: cycle %0d got dec=%h dv=%b bs=%0d bm=%0d step=%0d busy=%b required all zero",
                 c, dec, dec_valid, best_state, best_metric, step, busy);
      end
    end
  endtask

  task automatic test_zero_stream();
    set_hd_all(1);
    apply(1, 0);
    n_checks++;
    if (busy !== 1'b1 || dec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL start_busy: got busy=%b dv=%b required busy=1 dv=0", busy, dec_valid);
    end
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 16; i++) hd[i] = 2'($urandom_range(1, 2));
      hd[0] = 2'd0;
      hd[1] = 2'd2;
      apply(0, 1);
      n_checks++;
      if (dec_valid !== 1'b1 || best_state !== 3'd0 || best_metric !== '0 ||
          step !== 8'(k) || dec !== 8'(exp_dec)) begin
        n_fail++;
        $display("FAIL zero_stream: step %0d got dv=%b bs=%0d bm=%0d step=%0d dec=%h required dv=1 bs=0 bm=0 step=%0d dec=%h",
                 k, dec_valid, best_state, best_metric, step, dec, k, exp_dec);
      end
    end
  endtask

  task automatic test_tie();
    apply(1, 0);
    set_hd_all(0);
    repeat (3) apply(0, 1);
    for (int k = 0; k < 4; k++) begin
      set_hd_all($urandom_range(0, 2));
      apply(0, 1);
      n_checks++;
      if (dec !== 8'h00 || best_state !== 3'd0 || best_metric !== PM_W'(exp_bm)) begin
        n_fail++;
        $display("FAIL tie_rule: k=%0d got dec=%h bs=%0d bm=%0d required dec=00 bs=0 bm=%0d",
                 k, dec, best_state, best_metric, exp_bm);
      end
    end
  endtask

  task automatic test_renorm();
    apply(1, 0);
    set_hd_all(2);
    for (int k = 0; k < 40; k++) begin
      apply(0, 1);
      n_checks++;
      if (dec_valid !== 1'b1 || dec !== 8'(exp_dec) || best_state !== 3'(exp_best) ||
          best_metric !== PM_W'(exp_bm)) begin
        n_fail++;
        $display("FAIL renorm: step %0d got dec=%h bs=%0d bm=%0d required dec=%h bs=%0d bm=%0d",
                 k, dec, best_state, best_metric, exp_dec, exp_best, exp_bm);
      end
    end
  endtask

  task automatic test_back_to_back();
    apply(1, 0);
    for (int k = 0; k < 320; k++) begin
      bit v;
      v = (k < 270) ? 1'b1 : ($urandom_range(0, 3) != 0);
      set_hd_rand();
      apply(0, v);
      n_checks++;
      if (dec_valid !== exp_dv || dec !== 8'(exp_dec) || best_state !== 3'(exp_best) ||
          best_metric !== PM_W'(exp_bm) || step !== 8'(exp_step) || busy !== m_run) begin
        n_fail++;
        $display("FAIL back_to_back: cycle %0d got dv=%b dec=%h bs=%0d bm=%0d step=%0d busy=%b required dv=%b dec=%h bs=%0d bm=%0d step=%0d busy=%b",
                 k, dec_valid, dec, best_state, best_metric, step, busy,
                 exp_dv, exp_dec, exp_best, exp_bm, exp_step, m_run);
      end
    end
  endtask

  task automatic test_start_mid_run();
    set_hd_rand();
    repeat (5) apply(0, 1);
    set_hd_rand();
    apply(1, 1);
    n_checks++;
    if (dec_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_mid_run_dv: got dv=%b busy=%b required dv=0 busy=1", dec_valid, busy);
    end
    set_hd_all(0);
    apply(0, 1);
    n_checks++;
    if (dec_valid !== 1'b1 || step !== 8'd0 || dec !== 8'(exp_dec) ||
        best_state !== 3'(exp_best) || best_metric !== PM_W'(exp_bm)) begin
      n_fail++;
      $display("FAIL start_mid_run_step: got dv=%b step=%0d dec=%h bs=%0d bm=%0d required dv=1 step=0 dec=%h bs=%0d bm=%0d",
               dec_valid, step, dec, best_state, best_metric, exp_dec, exp_best, exp_bm);
    end
    set_hd_all(2);
    apply(0, 1);
    n_checks++;
    if (step !== 8'd1 || best_metric !== PM_W'(exp_bm) || dec !== 8'(exp_dec)) begin
      n_fail++;
      $display("FAIL start_mid_run_next: got step=%0d bm=%0d dec=%h required step=1 bm=%0d dec=%h",
               step, best_metric, dec, exp_bm, exp_dec);
    end
  endtask

  task automatic test_reset_mid_run();
    set_hd_all(1);
    repeat (3) apply(0, 1);
    @(negedge clock);
    start = 1'b0; bm_valid = 1'b1;
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({dec, dec_valid, best_state, best_metric, step, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got dec=%h dv=%b bs=%0d bm=%0d step=%0d busy=%b required all zero",
               dec, dec_valid, best_state, best_metric, step, busy);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      apply(0, 1);
      n_checks++;
      if (dec_valid !== 1'b0 || busy !== 1'b0 || best_metric !== '0) begin
        n_fail++;
        $display("FAIL after_reset_idle: cycle %0d got dv=%b busy=%b bm=%0d required dv=0 busy=0 bm=0",
                 c, dec_valid, busy, best_metric);
      end
    end
  endtask

  initial begin
    set_hd_all(0);
    model_reset();
    test_reset();
    test_zero_stream();
    test_tie();
    test_renorm();
    test_back_to_back();
    test_start_mid_run();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
